// File: rtl/vga_fb_ctrl.sv
// VGA framebuffer controller: H/V timing generator, double-buffered pixel
// store, back-buffer write port and frame-synchronous buffer swap.
// Sync and RGB leave through the same 3-stage pipeline so they stay aligned.
module vga_fb_ctrl #(
    parameter int   HD       = 1280,
    parameter int   VD       = 1024,
    parameter int   HF       = 48,
    parameter int   HR       = 112,
    parameter int   HB       = 248,
    parameter int   VF       = 1,
    parameter int   VR       = 3,
    parameter int   VB       = 38,
    parameter int   BPP      = 1,
    parameter logic SYNC_POL = 1'b0,
    parameter int   XW       = 11,
    parameter int   YW       = 11
) (
    input  logic           clk_i,
    input  logic           arst_i,
    input  logic           wr_valid_i,
    output logic           wr_ready_o,
    input  logic [XW-1:0]  wr_x_i,
    input  logic [YW-1:0]  wr_y_i,
    input  logic [BPP-1:0] wr_data_i,
    input  logic           swap_req_i,
    output logic           swap_pending_o,
    output logic           swap_done_o,
    output logic           front_sel_o,
    output logic           wr_oob_o,
    output logic           frame_start_o,
    output logic           vga_hs_o,
    output logic           vga_vs_o,
    output logic [11:0]    rgb_o
);

    localparam int HMAX = HD + HF + HR + HB - 1;
    localparam int VMAX = VD + VF + VR + VB - 1;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int VW   = $clog2(VMAX + 1);
    localparam int NPIX = HD * VD;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    // Line/frame order is sync, back porch, active, front porch.
    localparam int HBEG = HR + HB;
    localparam int HEND = HBEG + HD;
    localparam int VBEG = VR + VB;
    localparam int VEND = VBEG + VD;

    logic [HW-1:0]  hcount;
    logic [VW-1:0]  vcount;
    logic           h_last;
    logic           v_last;
    logic           swap_point;
    logic           pix_active;
    logic           hs_active;
    logic           vs_active;
    logic [AW-1:0]  rd_addr;
    logic [AW-1:0]  wr_addr;
    logic           wr_in_range;
    logic           wr_fire;

    logic           s1_act;
    logic           s1_hs;
    logic           s1_vs;
    logic           s1_sel;
    logic [AW-1:0]  s1_addr;
    logic           s2_act;
    logic           s2_hs;
    logic           s2_vs;
    logic [BPP-1:0] rd_data;
    logic [11:0]    pix_rgb;

    logic [BPP-1:0] mem0 [NPIX];
    logic [BPP-1:0] mem1 [NPIX];

    assign h_last     = (32'(hcount) == HMAX);
    assign v_last     = (32'(vcount) == VMAX);
    // Swap lands on the last clock of the last visible line, so the next
    // visible pixel already belongs to the new frame.
    assign swap_point = h_last && (32'(vcount) == VEND - 1) && swap_pending_o;

    assign hs_active  = (32'(hcount) < HR);
    assign vs_active  = (32'(vcount) < VR);
    assign pix_active = (32'(hcount) >= HBEG) && (32'(hcount) < HEND) &&
                        (32'(vcount) >= VBEG) && (32'(vcount) < VEND);
    assign rd_addr    = AW'((32'(vcount) - 32'(VBEG)) * 32'(HD) +
                            (32'(hcount) - 32'(HBEG)));

    // Ready is forced low during reset and while a swap is waiting, which
    // keeps the back buffer frozen until it becomes the front.
    assign wr_ready_o  = ~arst_i & ~swap_pending_o;
    assign wr_fire     = wr_valid_i & wr_ready_o;
    assign wr_in_range = (32'(wr_x_i) < HD) && (32'(wr_y_i) < VD);
    assign wr_addr     = AW'(32'(wr_y_i) * 32'(HD) + 32'(wr_x_i));

    // Pixel value to 12-bit colour.
    generate
        if (BPP == 1) begin : gen_bpp1
            assign pix_rgb = {12{rd_data[0]}};
        end else if (BPP == 4) begin : gen_bpp4
            assign pix_rgb = {3{rd_data}};
        end else begin : gen_bpp12
            assign pix_rgb = rd_data;
        end
    endgenerate

    // Horizontal/vertical counters, wrapping at HMAX/VMAX.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            hcount <= '0;
            vcount <= '0;
        end else if (h_last) begin
            hcount <= '0;
            vcount <= v_last ? '0 : vcount + VW'(1);
        end else begin
            hcount <= hcount + HW'(1);
        end
    end

    // Swap handshake, sticky out-of-range flag and frame-start pulse.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            front_sel_o    <= 1'b0;
            swap_pending_o <= 1'b0;
            swap_done_o    <= 1'b0;
            wr_oob_o       <= 1'b0;
            frame_start_o  <= 1'b0;
        end else begin
            swap_done_o   <= swap_point;
            frame_start_o <= (hcount == '0) && (vcount == '0);
            if (swap_point) begin
                front_sel_o    <= ~front_sel_o;
                swap_pending_o <= 1'b0;
            end else if (swap_req_i && !swap_pending_o) begin
                swap_pending_o <= 1'b1;
            end
            if (wr_fire && !wr_in_range) begin
                wr_oob_o <= 1'b1;
            end
        end
    end

    // Pixel store: writes go to the back buffer, reads (S2) come from the
    // buffer selected when the pixel entered S1. Contents are not reset.
    always_ff @(posedge clk_i) begin
        if (wr_fire && wr_in_range) begin
            if (front_sel_o) begin
                mem0[wr_addr] <= wr_data_i;
            end else begin
                mem1[wr_addr] <= wr_data_i;
            end
        end
        rd_data <= s1_sel ? mem1[s1_addr] : mem0[s1_addr];
    end

    // S1/S2/S3 pipeline; sync bits ride alongside the pixel data.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            s1_act   <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_sel   <= 1'b0;
            s1_addr  <= '0;
            s2_act   <= 1'b0;
            s2_hs    <= 1'b0;
            s2_vs    <= 1'b0;
            rgb_o    <= '0;
            vga_hs_o <= ~SYNC_POL;
            vga_vs_o <= ~SYNC_POL;
        end else begin
            s1_act   <= pix_active;
            s1_hs    <= hs_active;
            s1_vs    <= vs_active;
            s1_sel   <= front_sel_o;
            s1_addr  <= pix_active ? rd_addr : '0;
            s2_act   <= s1_act;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
            rgb_o    <= s2_act ? pix_rgb : '0;
            vga_hs_o <= s2_hs ? SYNC_POL : ~SYNC_POL;
            vga_vs_o <= s2_vs ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Bench for vga_fb_ctrl in a tiny 4x2 mode (7 clocks/line, 35 clocks/frame).
// The bench tracks clocks since reset release and derives expected outputs
// from that position in the frame.
module tb_vga_fb_ctrl;

    localparam int HD = 4, VD = 2, HF = 1, HR = 1, HB = 1;
    localparam int VF = 1, VR = 1, VB = 1, BPP = 4, XW = 3, YW = 3;
    localparam int FRAME = 35;

    logic           clk_i = 1'b0;
    logic           arst_i;
    logic           wr_valid_i;
    logic           wr_ready_o;
    logic [XW-1:0]  wr_x_i;
    logic [YW-1:0]  wr_y_i;
    logic [BPP-1:0] wr_data_i;
    logic           swap_req_i;
    logic           swap_pending_o;
    logic           swap_done_o;
    logic           front_sel_o;
    logic           wr_oob_o;
    logic           frame_start_o;
    logic           vga_hs_o;
    logic           vga_vs_o;
    logic [11:0]    rgb_o;

    vga_fb_ctrl #(
        .HD(HD), .VD(VD), .HF(HF), .HR(HR), .HB(HB),
        .VF(VF), .VR(VR), .VB(VB), .BPP(BPP), .SYNC_POL(1'b0),
        .XW(XW), .YW(YW)
    ) dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_x_i(wr_x_i), .wr_y_i(wr_y_i), .wr_data_i(wr_data_i),
        .swap_req_i(swap_req_i), .swap_pending_o(swap_pending_o),
        .swap_done_o(swap_done_o), .front_sel_o(front_sel_o),
        .wr_oob_o(wr_oob_o), .frame_start_o(frame_start_o),
        .vga_hs_o(vga_hs_o), .vga_vs_o(vga_vs_o), .rgb_o(rgb_o)
    );

    always #5 clk_i = ~clk_i;

    // Clock edges since reset release; equals hcount+7*vcount modulo FRAME.
    int n;
    always @(posedge clk_i or posedge arst_i) begin
        if (arst_i) n <= 0;
        else        n <= n + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Pixel patterns, nibble i = pixel y*4+x.
    logic [31:0] p0 = 32'h421BCDEF;
    logic [31:0] p1 = 32'hAC987653;
    logic [31:0] p5 = 32'h53219876;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (clock %0d)", tag, got, exp, n);
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic wait_pos(input int p);
        int budget;
        budget = 0;
        while ((n % FRAME) != p && budget < 80) begin
            tick();
            budget++;
        end
        if ((n % FRAME) != p) begin
            n_checks++;
            $display("FAIL wait_pos: frame position %0d reached, wanted %0d", n % FRAME, p);
        end
    endtask

    task automatic wr_px(input int x, input int y, input int d);
        wr_valid_i = 1'b1;
        wr_x_i     = XW'(x);
        wr_y_i     = YW'(y);
        wr_data_i  = BPP'(d);
        tick();
        wr_valid_i = 1'b0;
    endtask

    task automatic fill(input logic [31:0] pat);
        for (int i = 0; i < 8; i++) wr_px(i % 4, i / 4, int'(pat[4*i +: 4]));
    endtask

    task automatic req_swap();
        swap_req_i = 1'b1;
        tick();
        swap_req_i = 1'b0;
    endtask

    // Waits for swap_done and checks it appears right after the swap point.
    task automatic wait_swap(input string tag);
        int budget;
        budget = 0;
        while (!swap_done_o && budget < 80) begin
            tick();
            budget++;
        end
        check({tag, "_done"}, 32'(swap_done_o), 1);
        check({tag, "_pos"}, n % FRAME, 28);
    endtask

    // Pixel (x,y) is on the counters at position (2+y)*7+(2+x), seen 3 clocks later.
    task automatic check_frame(input string tag, input logic [31:0] pat);
        int p;
        for (int i = 0; i < 8; i++) begin
            p = (2 + i / 4) * 7 + (2 + i % 4) + 3;
            wait_pos(p);
            check(tag, 32'(rgb_o), 32'(pat[4*i +: 4]) * 32'h111);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int hs_cnt, vs_cnt, fs_cnt, blank_nz, q;
        logic act_exp;
        arst_i = 1'b1; wr_valid_i = 1'b0; wr_x_i = '0; wr_y_i = '0;
        wr_data_i = '0; swap_req_i = 1'b0;
        repeat (3) tick();

        check("rst_hs",      32'(vga_hs_o), 1);
        check("rst_vs",      32'(vga_vs_o), 1);
        check("rst_rgb",     32'(rgb_o), 0);
        check("rst_front",   32'(front_sel_o), 0);
        check("rst_pending", 32'(swap_pending_o), 0);
        check("rst_ready",   32'(wr_ready_o), 0);
        check("rst_fstart",  32'(frame_start_o), 0);

        // 1. free-run two frames
        arst_i = 1'b0;
        hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; blank_nz = 0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (n >= 3 && n < 3 + FRAME) begin
                if (!vga_hs_o) hs_cnt++;
                if (!vga_vs_o) vs_cnt++;
            end
            if (frame_start_o) fs_cnt++;
            q = (n - 3) % FRAME;
            act_exp = (n >= 3) && (q % 7 >= 2) && (q % 7 <= 5) && (q / 7 >= 2) && (q / 7 <= 3);
            if (!act_exp && rgb_o != 12'h000) blank_nz++;
            if (n == 1) check("fstart_first", 32'(frame_start_o), 1);
            if (n == 2) check("hs_lag_before", 32'(vga_hs_o), 1);
            if (n == 3) check("hs_lag_at", 32'(vga_hs_o), 0);
            if (n == 4) check("hs_lag_after", 32'(vga_hs_o), 1);
            if (n == 9) check("vs_last_active", 32'(vga_vs_o), 0);
            if (n == 10) check("vs_release", 32'(vga_vs_o), 1);
        end
        check("hs_per_frame", hs_cnt, 5);
        check("vs_per_frame", vs_cnt, 7);
        check("fstart_count", fs_cnt, 2);
        check("blank_rgb_zero", blank_nz, 0);

        // 2. fill back buffer, swap, read back
        fill(p1);
        check("t2_ready_pre", 32'(wr_ready_o), 1);
        req_swap();
        check("t2_pending", 32'(swap_pending_o), 1);
        check("t2_ready_low", 32'(wr_ready_o), 0);
        check("t2_front_old", 32'(front_sel_o), 0);
        wait_swap("t2_swap");
        check("t2_front_new", 32'(front_sel_o), 1);
        check("t2_pending_clr", 32'(swap_pending_o), 0);
        check("t2_ready_back", 32'(wr_ready_o), 1);
        tick();
        check("t2_done_pulse", 32'(swap_done_o), 0);
        check_frame("t2_pix", p1);

        // 3. out-of-range writes
        fill(p0);
        wr_px(4, 0, 5);
        check("t3_oob_x", 32'(wr_oob_o), 1);
        wr_px(0, 2, 6);
        check("t3_oob_y", 32'(wr_oob_o), 1);
        req_swap();
        wait_swap("t3_swap");
        check("t3_front", 32'(front_sel_o), 0);
        check_frame("t3_pix", p0);
        check("t3_oob_sticky", 32'(wr_oob_o), 1);

        // 5. writes while front is displayed
        fill(p5);
        check_frame("t5_front_hold", p0);
        req_swap();
        wait_swap("t5_swap");
        check("t5_front", 32'(front_sel_o), 1);
        tick();
        check("t5_inflight_old", 32'(rgb_o), 32'h444);
        check_frame("t5_pix", p5);

        // 4. request exactly at the swap point, then a duplicate while pending
        wait_pos(27);
        swap_req_i = 1'b1;
        tick();
        swap_req_i = 1'b0;
        check("t4_no_swap_done", 32'(swap_done_o), 0);
        check("t4_no_swap_front", 32'(front_sel_o), 1);
        check("t4_pending", 32'(swap_pending_o), 1);
        tick();
        req_swap();
        wait_swap("t4_swap");
        check("t4_front", 32'(front_sel_o), 0);
        tick();
        check("t4_no_requeue", 32'(swap_pending_o), 0);
        wait_pos(28);
        check("t4_no_extra_done", 32'(swap_done_o), 0);
        check("t4_no_extra_front", 32'(front_sel_o), 0);
        check_frame("t4_pix", p0);

        // 6. reset mid-line with a swap pending and front_sel=1
        req_swap();
        wait_swap("t6_swap");
        req_swap();
        wait_pos(10);
        check("t6_pre_pending", 32'(swap_pending_o), 1);
        check("t6_pre_front", 32'(front_sel_o), 1);
        #2 arst_i = 1'b1;
        #1;
        check("t6_pending", 32'(swap_pending_o), 0);
        check("t6_front", 32'(front_sel_o), 0);
        check("t6_oob", 32'(wr_oob_o), 0);
        check("t6_done", 32'(swap_done_o), 0);
        check("t6_fstart", 32'(frame_start_o), 0);
        check("t6_rgb", 32'(rgb_o), 0);
        check("t6_hs", 32'(vga_hs_o), 1);
        check("t6_vs", 32'(vga_vs_o), 1);
        check("t6_ready", 32'(wr_ready_o), 0);
        repeat (2) tick();
        arst_i = 1'b0;
        tick();
        check("t6_fstart_restart", 32'(frame_start_o), 1);
        check("t6_ready_restart", 32'(wr_ready_o), 1);
        tick();
        check("t6_hs_before", 32'(vga_hs_o), 1);
        tick();
        check("t6_hs_restart", 32'(vga_hs_o), 0);
        check("t6_vs_restart", 32'(vga_vs_o), 0);
        wait_pos(28);
        check("t6_aborted_done", 32'(swap_done_o), 0);
        check("t6_aborted_front", 32'(front_sel_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
